// File: rtl/mem_access_unit_pkg.sv
// Shared MEM-stage definitions: access FSM states, Funct3 codes, request record and
// lane helpers used by mem_access_unit and its load extender.
package mem_access_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } mem_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } mem_size_e;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [2:0]  funct3;
    logic [1:0]  lane;
  } mem_req_t;

  // Unlisted Funct3 codes fall back to a full-word access.
  function automatic mem_size_e f3_size(input logic [2:0] f3);
    case (f3)
      F3_B, F3_BU: f3_size = SZ_B;
      F3_H, F3_HU: f3_size = SZ_H;
      default:     f3_size = SZ_W;
    endcase
  endfunction

  function automatic logic [3:0] lane_be(input mem_size_e sz, input logic [1:0] lane);
    case (sz)
      SZ_B:    lane_be = 4'b0001 << lane;
      SZ_H:    lane_be = lane[1] ? 4'b1100 : 4'b0011;
      default: lane_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_wdata(input mem_size_e sz, input logic [31:0] wd);
    case (sz)
      SZ_B:    lane_wdata = {4{wd[7:0]}};
      SZ_H:    lane_wdata = {2{wd[15:0]}};
      default: lane_wdata = wd;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_load_extend.sv
// Load lane select and sign/zero extension of a bus read word.
module mem_access_unit_load_extend
  import mem_access_unit_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  lane_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (lane_i)
      2'd0:    byte_sel = rdata_i[7:0];
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      default: byte_sel = rdata_i[31:24];
    endcase
    half_sel = lane_i[1] ? rdata_i[31:16] : rdata_i[15:0];
  end

  always_comb begin
    case (funct3_i)
      F3_B:    data_o = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   data_o = {24'd0, byte_sel};
      F3_H:    data_o = {{16{half_sel[15]}}, half_sel};
      F3_HU:   data_o = {16'd0, half_sel};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access engine: single-outstanding req/ack bus with timeout.
// Optional misaligned-access trap enabled by defining MISALIGN_CHECK_EN.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic [31:0] load_data,
  output logic        bus_err,
  output logic        misalign,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  mem_state_e    state_q, state_d;
  mem_req_t      req_q, req_d, req_new;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]   load_data_q, load_data_d;
  logic          bus_err_q, bus_err_d;
  logic          access_valid;
  logic          mis;
  mem_size_e     size;
  logic [31:0]   ext_data;

  assign access_valid = mem_read | mem_write;
  assign size         = f3_size(funct3);

`ifdef MISALIGN_CHECK_EN
  always_comb begin
    case (size)
      SZ_H:    mis = addr[0];
      SZ_W:    mis = |addr[1:0];
      default: mis = 1'b0;
    endcase
  end
`else
  assign mis = 1'b0;
`endif

  always_comb begin
    req_new.we     = mem_write;
    req_new.addr   = {addr[31:2], 2'b00};
    req_new.be     = lane_be(size, addr[1:0]);
    req_new.wdata  = lane_wdata(size, wdata);
    req_new.funct3 = funct3;
    req_new.lane   = addr[1:0];
  end

  mem_access_unit_load_extend u_load_extend (
    .rdata_i  (bus_rdata),
    .funct3_i (req_q.funct3),
    .lane_i   (req_q.lane),
    .data_o   (ext_data)
  );

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    cnt_d       = cnt_q;
    load_data_d = load_data_q;
    bus_err_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (access_valid) begin
          if (mis) begin
            load_data_d = '0;
          end else begin
            state_d = ST_BUSY;
            req_d   = req_new;
            cnt_d   = '0;
          end
        end
      end
      ST_BUSY: begin
        if (bus_ack) begin
          state_d = ST_DONE;
          if (!req_q.we) load_data_d = ext_data;
        end else if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
          // Last permitted wait cycle passed without ack: abandon the access.
          state_d     = ST_DONE;
          bus_err_d   = 1'b1;
          load_data_d = '0;
          cnt_d       = cnt_q + CntW'(1);
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      req_q       <= '0;
      cnt_q       <= '0;
      load_data_q <= '0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      cnt_q       <= cnt_d;
      load_data_q <= load_data_d;
      bus_err_q   <= bus_err_d;
    end
  end

  assign bus_req   = (state_q == ST_BUSY);
  assign bus_we    = req_q.we;
  assign bus_addr  = req_q.addr;
  assign bus_be    = req_q.be;
  assign bus_wdata = req_q.wdata;
  assign load_data = load_data_q;
  assign bus_err   = bus_err_q;
  assign stall     = ((state_q == ST_IDLE) && access_valid && !mis) || (state_q == ST_BUSY);
  assign misalign  = (state_q == ST_IDLE) && access_valid && mis;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit (TIMEOUT_CYCLES = 4).
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        stall;
  logic [31:0] load_data;
  logic        bus_err;
  logic        misalign;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = '0;

  int errors = 0;
  int checks = 0;

  // Values observed by run_access.
  int          o_stall;
  int          o_req;
  logic [31:0] o_ld;
  logic        o_err;
  logic        o_we;
  logic [31:0] o_addr;
  logic [3:0]  o_be;
  logic [31:0] o_wd;

  always #5 clk = ~clk;

  mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .funct3    (funct3),
    .addr      (addr),
    .wdata     (wdata),
    .stall     (stall),
    .load_data (load_data),
    .bus_err   (bus_err),
    .misalign  (misalign),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_be    (bus_be),
    .bus_wdata (bus_wdata),
    .bus_ack   (bus_ack),
    .bus_rdata (bus_rdata)
  );

  // Presents one access and plays the memory; waits < 0 means never ack.
  task automatic run_access(input logic rd, input logic wr, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] wd, input int waits,
                            input logic [31:0] rdata);
    bit done;
    done = 1'b0;
    o_stall = 0;
    o_req = 0;
    @(posedge clk);
    #1;
    mem_read = rd; mem_write = wr; funct3 = f3; addr = a; wdata = wd;
    bus_ack = 1'b0; bus_rdata = rdata;
    for (int c = 0; c < 64 && !done; c++) begin
      @(negedge clk);
      if (stall) o_stall++;
      if (bus_req) begin
        if (o_req == 0) begin
          o_we = bus_we; o_addr = bus_addr; o_be = bus_be; o_wd = bus_wdata;
        end
        o_req++;
        bus_ack = (waits >= 0) && (o_req == waits + 1);
      end else if (o_req > 0) begin
        o_ld = load_data;
        o_err = bus_err;
        bus_ack = 1'b0;
        done = 1'b1;
      end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL access_bound: got no DONE, required DONE within 64 cycles");
    end
    @(posedge clk);
    #1;
    mem_read = 1'b0; mem_write = 1'b0; bus_ack = 1'b0;
  endtask

  task automatic test_reset;
    #3;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rst_stall: got %b required 0", stall); end
    checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b required 0", bus_req); end
    checks++; if ({bus_we, bus_be, bus_addr, bus_wdata} !== 69'd0) begin
      errors++; $display("FAIL rst_bus: got %h required 0", {bus_we, bus_be, bus_addr, bus_wdata});
    end
    checks++; if ({load_data, bus_err, misalign} !== 34'd0) begin
      errors++; $display("FAIL rst_out: got %h required 0", {load_data, bus_err, misalign});
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_lw;
    run_access(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 0, 32'hDEADBEEF);
    checks++; if (o_be !== 4'hF) begin errors++; $display("FAIL lw_be: got %h required f", o_be); end
    checks++; if (o_addr !== 32'h100) begin errors++; $display("FAIL lw_addr: got %h required 100", o_addr); end
    checks++; if (o_we !== 1'b0) begin errors++; $display("FAIL lw_we: got %b required 0", o_we); end
    checks++; if (o_stall !== 2) begin errors++; $display("FAIL lw_stall: got %0d required 2", o_stall); end
    checks++; if (o_ld !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_data: got %h required deadbeef", o_ld); end
  endtask

  task automatic test_byte_half;
    run_access(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 0, 32'h80FFFFFF);
    checks++; if (o_be !== 4'b1000) begin errors++; $display("FAIL lb_be: got %b required 1000", o_be); end
    checks++; if (o_ld !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_data: got %h required ffffff80", o_ld); end
    run_access(1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 0, 32'h80FFFFFF);
    checks++; if (o_ld !== 32'h00000080) begin errors++; $display("FAIL lbu_data: got %h required 00000080", o_ld); end
    run_access(1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 1, 32'h80017FFF);
    checks++; if (o_be !== 4'b1100) begin errors++; $display("FAIL lh_be: got %b required 1100", o_be); end
    checks++; if (o_ld !== 32'hFFFF8001) begin errors++; $display("FAIL lh_data: got %h required ffff8001", o_ld); end
    checks++; if (o_stall !== 3) begin errors++; $display("FAIL lh_stall: got %0d required 3", o_stall); end
    run_access(1'b1, 1'b0, 3'b101, 32'h100, 32'h0, 0, 32'h80017FFF);
    checks++; if (o_ld !== 32'h00007FFF) begin errors++; $display("FAIL lhu_data: got %h required 00007fff", o_ld); end
  endtask

  task automatic test_store;
    run_access(1'b0, 1'b1, 3'b001, 32'h202, 32'h1234ABCD, 3, 32'h0);
    checks++; if (o_we !== 1'b1) begin errors++; $display("FAIL sh_we: got %b required 1", o_we); end
    checks++; if (o_addr !== 32'h200) begin errors++; $display("FAIL sh_addr: got %h required 200", o_addr); end
    checks++; if (o_be !== 4'b1100) begin errors++; $display("FAIL sh_be: got %b required 1100", o_be); end
    checks++; if (o_wd !== 32'hABCDABCD) begin errors++; $display("FAIL sh_wdata: got %h required abcdabcd", o_wd); end
    checks++; if (o_stall !== 5) begin errors++; $display("FAIL sh_stall: got %0d required 5", o_stall); end
    checks++; if (o_ld !== 32'h00007FFF) begin errors++; $display("FAIL sh_keep: got %h required 00007fff", o_ld); end
    run_access(1'b1, 1'b1, 3'b000, 32'h001, 32'hAAAA0055, 0, 32'h0);
    checks++; if ({o_we, o_be, o_wd} !== {1'b1, 4'b0010, 32'h55555555}) begin
      errors++; $display("FAIL sb_lanes: got %h required 1255555555", {o_we, o_be, o_wd});
    end
  endtask

  task automatic test_timeout;
    run_access(1'b1, 1'b0, 3'b010, 32'h400, 32'h0, -1, 32'h12345678);
    checks++; if (o_req !== 4) begin errors++; $display("FAIL to_req: got %0d required 4", o_req); end
    checks++; if (o_err !== 1'b1) begin errors++; $display("FAIL to_err: got %b required 1", o_err); end
    checks++; if (o_ld !== 32'h0) begin errors++; $display("FAIL to_data: got %h required 0", o_ld); end
    checks++; if (o_stall !== 5) begin errors++; $display("FAIL to_stall: got %0d required 5", o_stall); end
    @(negedge clk);
    checks++; if ({bus_err, stall, bus_req} !== 3'b000) begin
      errors++; $display("FAIL to_after: got %b required 000", {bus_err, stall, bus_req});
    end
  endtask

  task automatic test_back_to_back;
    logic [5:0] req_seq;
    logic [5:0] stall_seq;
    @(posedge clk);
    #1;
    mem_read = 1'b1; funct3 = 3'b010; addr = 32'h40; bus_ack = 1'b1; bus_rdata = 32'h11111111;
    for (int i = 5; i >= 0; i--) begin
      @(negedge clk);
      req_seq[i] = bus_req;
      stall_seq[i] = stall;
    end
    checks++; if (req_seq !== 6'b010010) begin errors++; $display("FAIL b2b_req: got %b required 010010", req_seq); end
    checks++; if (stall_seq !== 6'b110110) begin errors++; $display("FAIL b2b_stall: got %b required 110110", stall_seq); end
    checks++; if (load_data !== 32'h11111111) begin errors++; $display("FAIL b2b_data: got %h required 11111111", load_data); end
    @(posedge clk);
    #1;
    mem_read = 1'b0; bus_ack = 1'b0;
  endtask

  task automatic test_reset_busy;
    @(posedge clk);
    #1;
    mem_read = 1'b1; funct3 = 3'b010; addr = 32'h300; bus_ack = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    checks++; if (bus_req !== 1'b1) begin errors++; $display("FAIL rb_busy: got %b required 1", bus_req); end
    reset = 1'b1;
    #1;
    checks++; if (bus_req !== 1'b0) begin errors++; $display("FAIL rb_req: got %b required 0", bus_req); end
    checks++; if (load_data !== 32'h0) begin errors++; $display("FAIL rb_data: got %h required 0", load_data); end
    mem_read = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    bus_ack = 1'b1; bus_rdata = 32'hCAFEF00D;
    @(posedge clk);
    #1;
    bus_ack = 1'b0;
    @(negedge clk);
    checks++; if ({bus_req, stall, load_data} !== 34'd0) begin
      errors++; $display("FAIL rb_late_ack: got %h required 0", {bus_req, stall, load_data});
    end
  endtask

  task automatic test_misalign;
`ifdef MISALIGN_CHECK_EN
    @(posedge clk);
    #1;
    mem_read = 1'b1; funct3 = 3'b010; addr = 32'h101;
    @(negedge clk);
    checks++; if ({misalign, stall, bus_req} !== 3'b100) begin
      errors++; $display("FAIL mis_pulse: got %b required 100", {misalign, stall, bus_req});
    end
    @(posedge clk);
    #1;
    mem_read = 1'b0;
    @(negedge clk);
    checks++; if ({misalign, bus_req, load_data} !== 34'd0) begin
      errors++; $display("FAIL mis_after: got %h required 0", {misalign, bus_req, load_data});
    end
`else
    run_access(1'b1, 1'b0, 3'b010, 32'h101, 32'h0, 0, 32'h0BADF00D);
    checks++; if (o_addr !== 32'h100) begin errors++; $display("FAIL mis_addr: got %h required 100", o_addr); end
    checks++; if (o_ld !== 32'h0BADF00D) begin errors++; $display("FAIL mis_data: got %h required 0badf00d", o_ld); end
    checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL mis_tie: got %b required 0", misalign); end
`endif
  endtask

  initial begin
    test_reset();
    test_lw();
    test_byte_half();
    test_store();
    test_timeout();
    test_back_to_back();
    test_reset_busy();
    test_misalign();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
